// File: rtl/dac_player_pkg.sv
// dac_pkg: shared types and constants for the DAC playback path.
// States, gpio_ctrl bit positions and stream lane geometry.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED,
    PLAY
  } state_e;

  localparam int GPIO_LOAD = 0;
  localparam int GPIO_ARM  = 1;
  localparam int GPIO_LOOP = 2;

  localparam int PS_W_DEF     = 32;
  localparam int SAMPLE_W_DEF = 128;
  localparam int LANES        = SAMPLE_W_DEF / PS_W_DEF;

endpackage

// File: rtl/dac_player_if.sv
// dac_player_if: AXI-Stream bundle used for both the CPU and DAC sides.
// Width is set per instance.
interface dac_player_if #(
  parameter int W = 32
) ();

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/dac_sample_ram.sv
// dac_sample_ram: simple dual-port sample buffer.
// One write port, registered read with enable, array not reset.
module dac_sample_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/dac_player.sv
// dac_player: packs 32-bit CPU words into 128-bit DAC words and
// replays the buffer on trigger, one-shot or looped.
module dac_player
  import dac_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int TRIGGER_LINE = 15,
  parameter int PS_W         = PS_W_DEF,
  parameter int SAMPLE_W     = SAMPLE_W_DEF
) (
  input  logic                   pl_clk,
  input  logic                   rst,
  input  logic [15:0]            gpio_ctrl,
  input  logic                   select_in,
  dac_player_if.slave            s_axis,
  dac_player_if.master           m_axis,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] length
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int LNW = $clog2(LANES);
  localparam int TRG = 3;

  state_e state_q, state_d;

  // {trigger, loop, arm, load}; low bits line up with GPIO_*
  logic [3:0]    cmd_q;
  logic [1:0]    cmd_p;
  logic          sel_q;

  logic [LW-1:0]       wr_ptr;
  logic [LNW-1:0]      lane;
  logic [SAMPLE_W-1:0] pack;
  logic [SAMPLE_W-1:0] wdata;

  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       out_idx;
  logic                out_act;
  logic [SAMPLE_W-1:0] tdata_q;
  logic                tvalid_q;

  logic [SAMPLE_W-1:0] ram_q;
  logic                ram_re;
  logic [AW-1:0]       ram_ra;

  logic load_rise, load_fall;
  logic arm_rise, arm_fall, trig;
  logic s_acc, wr_en, full;
  logic playing, adv, last_acc;
  logic [AW-1:0] last_idx, nxt_idx;
  logic start, abort, fin, go, stop;

  assign load_rise = sel_q &  cmd_q[GPIO_LOAD] & ~cmd_p[GPIO_LOAD];
  assign load_fall = sel_q & ~cmd_q[GPIO_LOAD] &  cmd_p[GPIO_LOAD];
  assign arm_rise  = sel_q &  cmd_q[GPIO_ARM]  & ~cmd_p[GPIO_ARM];
  assign arm_fall  = sel_q & ~cmd_q[GPIO_ARM]  &  cmd_p[GPIO_ARM];
  assign trig      = sel_q &  cmd_q[TRG];

  assign s_axis.tready = (state_q == LOAD);
  assign s_acc = s_axis.tvalid & s_axis.tready;
  assign full  = (wr_ptr == LW'(DEPTH - 1));
  assign wr_en = s_acc & ~load_fall &
                 (s_axis.tlast | (lane == LNW'(LANES - 1)));

  always_comb begin
    wdata = pack;
    for (int i = 0; i < LANES; i++)
      if (lane == LNW'(i))
        wdata[i*PS_W +: PS_W] = s_axis.tdata;
  end

  // rd_ptr names the word sitting in ram_q, one ahead of tdata
  assign last_idx = AW'(length - 1'b1);
  assign nxt_idx  = (rd_ptr == last_idx) ? '0 : rd_ptr + 1'b1;
  assign playing  = (state_q == PLAY);
  assign adv      = playing & (~out_act | m_axis.tready);
  assign last_acc = out_act & m_axis.tready &
                    (out_idx == last_idx);

  assign ram_re = go | adv;
  assign ram_ra = go ? '0 : nxt_idx;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    fin     = 1'b0;
    go      = 1'b0;
    stop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_rise) begin
          state_d = LOAD;
          start   = 1'b1;
        end else if (arm_rise && length != '0) begin
          state_d = ARMED;
        end
      end
      LOAD: begin
        if (load_fall) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (wr_en && (s_axis.tlast || full)) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
      ARMED: begin
        if (arm_fall) begin
          state_d = IDLE;
        end else if (trig) begin
          state_d = PLAY;
          go      = 1'b1;
        end
      end
      PLAY: begin
        if (arm_fall) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else if (last_acc && !cmd_q[GPIO_LOOP]) begin
          state_d = cmd_q[GPIO_ARM] ? ARMED : IDLE;
          stop    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      cmd_q    <= '0;
      cmd_p    <= '0;
      sel_q    <= 1'b0;
      length   <= '0;
      wr_ptr   <= '0;
      lane     <= '0;
      pack     <= '0;
      rd_ptr   <= '0;
      out_idx  <= '0;
      out_act  <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      cmd_q    <= {gpio_ctrl[TRIGGER_LINE],
                   gpio_ctrl[GPIO_LOOP],
                   gpio_ctrl[GPIO_ARM],
                   gpio_ctrl[GPIO_LOAD]};
      cmd_p    <= cmd_q[1:0];
      sel_q    <= select_in;
      tvalid_q <= 1'b1;

      if (start) begin
        wr_ptr <= '0;
        lane   <= '0;
        pack   <= '0;
        length <= '0;
      end else if (abort) begin
        length <= '0;
      end else if (s_acc) begin
        if (wr_en) begin
          pack   <= '0;
          lane   <= '0;
          wr_ptr <= wr_ptr + 1'b1;
          if (fin)
            length <= wr_ptr + 1'b1;
        end else begin
          pack <= wdata;
          lane <= lane + 1'b1;
        end
      end

      if (go) begin
        rd_ptr  <= '0;
        out_act <= 1'b0;
      end else if (stop) begin
        out_act <= 1'b0;
        tdata_q <= '0;
      end else if (adv) begin
        tdata_q <= ram_q;
        out_act <= 1'b1;
        out_idx <= rd_ptr;
        rd_ptr  <= nxt_idx;
      end
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = 1'b0;
  assign busy          = (state_q != IDLE);

  dac_sample_ram #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_ram (
    .clk   (pl_clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_ra),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_dac_player.sv
// tb_dac_player: random loads and playback of dac_player
// checked against a word-level model of the buffer.
module tb_dac_player;
  import dac_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TRIG  = 15;

  logic          pl_clk = 1'b0;
  logic          rst;
  logic [15:0]   gpio_ctrl;
  logic          select_in;
  logic          busy;
  logic [LW-1:0] length;

  dac_player_if #(.W(32))  s_if ();
  dac_player_if #(.W(128)) m_if ();

  dac_player #(
    .DEPTH        (DEPTH),
    .TRIGGER_LINE (TRIG)
  ) dut (
    .pl_clk    (pl_clk),
    .rst       (rst),
    .gpio_ctrl (gpio_ctrl),
    .select_in (select_in),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .busy      (busy),
    .length    (length)
  );

  always #5 pl_clk = ~pl_clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  src [$];
  logic [127:0] mdl [DEPTH];
  int           mdl_len = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pl_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Buffer contents implied by the first n words of src
  function automatic void build_model(input int n, input bit last);
    int nw;
    if (last)
      nw = (n + LANES - 1) / LANES;
    else if (n >= LANES * DEPTH)
      nw = DEPTH;
    else
      nw = 0;
    for (int k = 0; k < nw; k++) begin
      mdl[k] = '0;
      for (int j = 0; j < LANES; j++)
        if (k * LANES + j < n)
          mdl[k][j*32 +: 32] = src[k*LANES + j];
    end
    mdl_len = nw;
  endfunction

  task automatic do_load(input int n, input bit last, input bit gaps);
    int i;
    int cyc;
    int exp_acc;
    bit acc;
    i = 0;
    cyc = 0;
    gpio_ctrl = '0;
    ticks(2);
    gpio_ctrl[GPIO_LOAD] = 1'b1;
    ticks(2);
    chk("load_ready", s_if.tready, 1);
    while (i < n && cyc < 8 * n + 64) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
      end else begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = src[i];
        s_if.tlast  = last && (i == n - 1);
      end
      if (s_if.tvalid && !s_if.tready)
        break;
      acc = s_if.tvalid && s_if.tready;
      tick();
      cyc++;
      if (acc)
        i++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    gpio_ctrl[GPIO_LOAD] = 1'b0;
    ticks(2);
    exp_acc = (!last && n > LANES * DEPTH) ? LANES * DEPTH : n;
    chk("load_accepted", i, exp_acc);
    build_model(i, last);
    chk("load_length", length, mdl_len);
    chk("load_idle", busy, 0);
    chk("load_ready_low", s_if.tready, 0);
  endtask

  // Leaves the bench in cycle T+2 after the trigger sample
  task automatic arm_and_trigger(input bit loop);
    gpio_ctrl = '0;
    gpio_ctrl[GPIO_ARM]  = 1'b1;
    gpio_ctrl[GPIO_LOOP] = loop;
    ticks(2);
    chk("armed", busy, 1);
    chk("armed_zero", m_if.tdata, 0);
    gpio_ctrl[TRIG] = 1'b1;
    tick();
    gpio_ctrl[TRIG] = 1'b0;
    ticks(2);
  endtask

  task automatic disarm();
    gpio_ctrl[GPIO_ARM] = 1'b0;
    ticks(2);
    chk("disarmed", busy, 0);
  endtask

  task automatic play_once(input bit rnd);
    int p;
    int cyc;
    bit rdy;
    bit done;
    arm_and_trigger(1'b0);
    p = 0;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 4 * mdl_len + 32) begin
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_if.tready = rdy;
      chk("play_word", m_if.tdata, mdl[p]);
      if (rdy) begin
        if (p == mdl_len - 1)
          done = 1'b1;
        else
          p++;
      end
      tick();
      cyc++;
    end
    chk("play_done", done, 1);
    chk("tail_zero", m_if.tdata, 0);
    chk("rearmed", busy, 1);
    tick();
    chk("tail_zero2", m_if.tdata, 0);
    m_if.tready = 1'b1;
    disarm();
  endtask

  task automatic play_loop(input bit rnd, input int ncyc);
    int p;
    bit rdy;
    arm_and_trigger(1'b1);
    p = 0;
    for (int k = 0; k < ncyc + 2; k++) begin
      if (k == ncyc)
        gpio_ctrl[GPIO_ARM] = 1'b0;
      if (rnd)
        rdy = ($urandom_range(0, 2) != 0);
      else
        rdy = !(k >= 5 && k < 8);
      m_if.tready = rdy;
      chk("loop_word", m_if.tdata, mdl[p]);
      if (rdy)
        p = (p + 1) % mdl_len;
      tick();
    end
    chk("loop_stop_zero", m_if.tdata, 0);
    chk("loop_stop_idle", busy, 0);
    m_if.tready = 1'b1;
  endtask

  task automatic fill_seq(input int n);
    src = {};
    for (int i = 1; i <= n; i++)
      src.push_back(32'(i));
  endtask

  task automatic fill_rand(input int n);
    src = {};
    for (int i = 0; i < n; i++)
      src.push_back($urandom);
  endtask

  initial begin
    rst         = 1'b1;
    gpio_ctrl   = '0;
    select_in   = 1'b1;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    ticks(3);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_length", length, 0);
    chk("rst_sready", s_if.tready, 0);
    rst = 1'b0;
    tick();
    chk("run_tvalid", m_if.tvalid, 1);
    chk("idle_tdata", m_if.tdata, 0);

    select_in = 1'b0;
    gpio_ctrl[GPIO_LOAD] = 1'b1;
    ticks(3);
    chk("sel_gate_busy", busy, 0);
    chk("sel_gate_ready", s_if.tready, 0);
    gpio_ctrl = '0;
    ticks(2);
    select_in = 1'b1;
    tick();

    fill_rand(6);
    do_load(6, 1'b0, 1'b0);
    gpio_ctrl[GPIO_ARM] = 1'b1;
    ticks(2);
    chk("arm_len0_ignored", busy, 0);
    gpio_ctrl = '0;
    ticks(2);

    fill_seq(8);
    do_load(8, 1'b1, 1'b0);
    arm_and_trigger(1'b0);
    m_if.tready = 1'b1;
    chk("t2_w0", m_if.tdata,
        128'h00000004_00000003_00000002_00000001);
    tick();
    chk("t3_w1", m_if.tdata,
        128'h00000008_00000007_00000006_00000005);
    tick();
    chk("t4_zero", m_if.tdata, 0);
    chk("t4_armed", busy, 1);
    tick();
    chk("t5_zero", m_if.tdata, 0);
    disarm();

    fill_seq(5);
    do_load(5, 1'b1, 1'b0);
    arm_and_trigger(1'b0);
    chk("p5_w0", m_if.tdata,
        128'h00000004_00000003_00000002_00000001);
    tick();
    chk("p5_w1", m_if.tdata, {96'h0, 32'h5});
    tick();
    chk("p5_zero", m_if.tdata, 0);
    disarm();

    fill_seq(8);
    do_load(8, 1'b1, 1'b0);
    play_loop(1'b0, 20);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 40);
      fill_rand(n);
      do_load(n, 1'b1, 1'b1);
      play_once(1'b1);
      if (r % 2 == 1)
        play_loop(1'b1, 25);
    end

    fill_rand(DEPTH * 4 + 3);
    do_load(DEPTH * 4 + 3, 1'b0, 1'b1);
    play_once(1'b1);

    fill_rand(11);
    do_load(11, 1'b1, 1'b1);
    arm_and_trigger(1'b1);
    ticks(3);
    rst       = 1'b1;
    gpio_ctrl = '0;
    tick();
    chk("rst_play_tvalid", m_if.tvalid, 0);
    chk("rst_play_tdata", m_if.tdata, 0);
    chk("rst_play_busy", busy, 0);
    chk("rst_play_length", length, 0);
    rst = 1'b0;
    tick();
    chk("rst_play_tvalid1", m_if.tvalid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
